trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DW, 32, width of captured PC and instruction words.
REQ-002 Parameter DEPTH, 16, number of entries; SHALL be a power of two, >= 4.
REQ-003 Parameter POST_CNT, 4, entries captured after a trigger; SHALL be < DEPTH.
REQ-004 Parameter CW, $clog2(DEPTH)+1, width of count_o.
REQ-005 clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous and active-low.
REQ-007 arm_i  input  1  pulse: clear buffer and enter CAPTURE.
REQ-008 stop_i  input  1  pulse: end capture, freeze buffer.
REQ-009 mode_i  input  2  00 wrap, 01 stop-on-full, 10 trigger; 11 treated as 01.
REQ-010 trig_pc_i  input  DW  trigger PC for mode 10.
REQ-011 cap_valid_i  input  1  cap_pc_i/cap_instr_i hold a valid pipeline entry this cycle.
REQ-012 cap_pc_i  input  DW  PC to capture.
REQ-013 cap_instr_i  input  DW  instruction word to capture.
REQ-014 rd_ready_i  input  1  consumer accepts rd_* this cycle.
REQ-015 rd_valid_o  output  1  oldest stored entry is presented.
REQ-016 rd_pc_o  output  DW  PC of oldest entry; 0 when rd_valid_o=0.
REQ-017 rd_instr_o  output  DW  instruction of oldest entry; 0 when rd_valid_o=0.
REQ-018 count_o  output  CW  stored entries, 0..DEPTH.
REQ-019 state_o  output  2  00 IDLE, 01 CAPTURE, 10 POST, 11 DONE.
REQ-020 overflow_o  output  1  sticky: an entry was overwritten in mode 00.

Function
REQ-021 States IDLE, CAPTURE, POST, DONE; one transition per edge max.
REQ-022 arm_i in any state SHALL zero write/read pointers, count and overflow, latch mode_i, go CAPTURE; arm_i beats stop_i and capture in the same cycle.
REQ-023 In CAPTURE/POST, cap_valid_i=1 SHALL write {cap_pc_i, cap_instr_i} at the write pointer on that edge, advance it modulo DEPTH, count_o updated on the same edge; cap_valid_i=0 writes nothing.
REQ-024 Mode 00, full: write SHALL overwrite the oldest entry, advance the read pointer, hold count at DEPTH, set overflow_o.
REQ-025 Mode 01: the write making count DEPTH SHALL move state to DONE; no later writes.
REQ-026 Mode 10, CAPTURE: a valid entry with cap_pc_i == trig_pc_i SHALL be written and move state to POST with post counter = POST_CNT; full-buffer writes wrap as in mode 00.
REQ-027 POST: each valid write decrements the post counter; the write reaching 0 SHALL move state to DONE.
REQ-028 stop_i in CAPTURE or POST SHALL move state to DONE on that edge; a coincident cap_valid_i entry is still written.
REQ-029 stop_i in IDLE or DONE SHALL be ignored.
REQ-030 rd_valid_o SHALL equal (state==DONE && count_o!=0), combinational; rd_* reflect the read-pointer entry, no added latency.
REQ-031 rd_valid_o && rd_ready_i SHALL pop: advance read pointer modulo DEPTH, decrement count_o on that edge.
REQ-032 rd_pc_o/rd_instr_o SHALL stay stable while rd_valid_o=1 and rd_ready_i=0.
REQ-033 Entries SHALL read out oldest-first; DONE with count 0 persists until arm_i.

Reset
REQ-034 rst_ni=0 SHALL immediately force state IDLE, pointers/count/post counter 0, overflow_o 0, rd_valid_o 0, rd_pc_o 0, rd_instr_o 0, count_o 0, including mid-capture or mid-readout.
REQ-035 Buffer storage need not be cleared by reset.

Verification (DEPTH=16, POST_CNT=4; captures PC=0,4,8,... one per cycle)
REQ-036 Mode 01, arm, 20 valid captures -> DONE after 16th, count_o=16, readout PCs 0..60 in order, overflow_o=0.
REQ-037 Mode 00, arm, 20 captures, stop_i -> count_o=16, overflow_o=1, readout PCs 16..76, then rd_valid_o=0.
REQ-038 Mode 10, trig_pc_i=40, 20 captures -> POST after PC 40, DONE after PC 56, count_o=15, readout 0..56.
REQ-039 DONE, rd_ready_i low 3 cycles then high -> rd_pc_o held, count_o unchanged, then one pop per cycle.
REQ-040 rst_ni low mid-capture (count 7) -> same cycle state IDLE, count_o 0, rd_valid_o 0; later captures ignored until arm_i.
REQ-041 arm_i and stop_i same cycle, cap_valid_i alternating -> CAPTURE, count_o 0, only valid cycles counted.

Source files
------------

// File: rtl/trace_buffer.sv
// Instruction trace buffer: captures {PC, instruction} pairs into a circular
// store under wrap, stop-on-full or trigger modes, then drains oldest-first.
module trace_buffer #(
   parameter int unsigned DW       = 32,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned POST_CNT = 4,
   parameter int unsigned CW       = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          arm_i,
   input  logic          stop_i,
   input  logic [1:0]    mode_i,
   input  logic [DW-1:0] trig_pc_i,
   input  logic          cap_valid_i,
   input  logic [DW-1:0] cap_pc_i,
   input  logic [DW-1:0] cap_instr_i,
   input  logic          rd_ready_i,
   output logic          rd_valid_o,
   output logic [DW-1:0] rd_pc_o,
   output logic [DW-1:0] rd_instr_o,
   output logic [CW-1:0] count_o,
   output logic [1:0]    state_o,
   output logic          overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_CAPTURE = 2'b01,
      S_POST    = 2'b10,
      S_DONE    = 2'b11
   } state_t;

   localparam logic [1:0] MODE_WRAP = 2'b00;
   localparam logic [1:0] MODE_STOP = 2'b01;
   localparam logic [1:0] MODE_TRIG = 2'b10;

   state_t           state;
   logic [1:0]       mode;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    post_cnt;
   logic [CW-1:0]    count;
   logic             overflow;
   logic [2*DW-1:0]  mem [DEPTH];

   logic             full;
   logic             wr_en;
   logic             pop;
   logic             trig_hit;
   logic [2*DW-1:0]  rd_word;

   // Write/pop qualifiers; arm takes priority over any capture or pop.
   always_comb begin
      full     = (count == CW'(DEPTH));
      wr_en    = !arm_i && cap_valid_i && ((state == S_CAPTURE) || (state == S_POST));
      pop      = !arm_i && rd_valid_o && rd_ready_i;
      trig_hit = (mode == MODE_TRIG) && (cap_pc_i == trig_pc_i);
   end

   // Read port presents the oldest entry with no added latency, zero when empty.
   always_comb begin
      rd_valid_o = (state == S_DONE) && (count != '0);
      rd_word    = mem[rd_ptr];
      rd_pc_o    = rd_valid_o ? rd_word[2*DW-1:DW] : '0;
      rd_instr_o = rd_valid_o ? rd_word[DW-1:0]    : '0;
   end

   // Storage array, deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_ptr] <= {cap_pc_i, cap_instr_i};
      end
   end

   // Control FSM with pointers, occupancy, post-trigger counter and sticky overflow.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= S_IDLE;
         mode     <= MODE_WRAP;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         post_cnt <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (arm_i) begin
         state    <= S_CAPTURE;
         mode     <= (mode_i == 2'b11) ? MODE_STOP : mode_i;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         post_cnt <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (full) begin
               rd_ptr   <= rd_ptr + AW'(1);
               overflow <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - CW'(1);
         end
         case (state)
            S_CAPTURE: begin
               if (stop_i) begin
                  state <= S_DONE;
               end else if (wr_en) begin
                  if ((mode == MODE_STOP) && (count == CW'(DEPTH - 1))) begin
                     state <= S_DONE;
                  end else if (trig_hit) begin
                     post_cnt <= AW'(POST_CNT);
                     state    <= (POST_CNT == 0) ? S_DONE : S_POST;
                  end
               end
            end
            S_POST: begin
               if (wr_en) begin
                  post_cnt <= post_cnt - AW'(1);
                  if (post_cnt == AW'(1)) begin
                     state <= S_DONE;
                  end
               end
               if (stop_i) begin
                  state <= S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign count_o    = count;
   assign state_o    = state;
   assign overflow_o = overflow;

endmodule

// File: tb/tb_trace_buffer.sv
// Randomised and directed bench for trace_buffer with a queue-based reference
// model and a decoupled read-out scoreboard.
module tb_trace_buffer;

   localparam int DW       = 32;
   localparam int DEPTH    = 16;
   localparam int POST_CNT = 4;
   localparam int CW       = $clog2(DEPTH) + 1;

   typedef struct {
      logic [DW-1:0] pc;
      logic [DW-1:0] instr;
   } ent_t;

   logic          clk_i       = 1'b0;
   logic          rst_ni      = 1'b1;
   logic          arm_i       = 1'b0;
   logic          stop_i      = 1'b0;
   logic [1:0]    mode_i      = 2'b00;
   logic [DW-1:0] trig_pc_i   = '0;
   logic          cap_valid_i = 1'b0;
   logic [DW-1:0] cap_pc_i    = '0;
   logic [DW-1:0] cap_instr_i = '0;
   logic          rd_ready_i  = 1'b0;
   logic          rd_valid_o;
   logic [DW-1:0] rd_pc_o;
   logic [DW-1:0] rd_instr_o;
   logic [CW-1:0] count_o;
   logic [1:0]    state_o;
   logic          overflow_o;

   trace_buffer #(.DW(DW), .DEPTH(DEPTH), .POST_CNT(POST_CNT), .CW(CW)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .arm_i       (arm_i),
      .stop_i      (stop_i),
      .mode_i      (mode_i),
      .trig_pc_i   (trig_pc_i),
      .cap_valid_i (cap_valid_i),
      .cap_pc_i    (cap_pc_i),
      .cap_instr_i (cap_instr_i),
      .rd_ready_i  (rd_ready_i),
      .rd_valid_o  (rd_valid_o),
      .rd_pc_o     (rd_pc_o),
      .rd_instr_o  (rd_instr_o),
      .count_o     (count_o),
      .state_o     (state_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model: stored entries oldest-first, state 0..3, latched mode.
   ent_t mq[$];
   ent_t exp_q[$];
   int   m_st   = 0;
   int   m_mode = 0;
   int   m_post = 0;
   bit   m_ovf  = 1'b0;
   ent_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit has;
      has = (m_st == 3) && (mq.size() > 0);
      chk("state",    64'(state_o),    64'(m_st));
      chk("count",    64'(count_o),    64'(mq.size()));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("rd_valid", 64'(rd_valid_o), 64'(has));
      chk("rd_pc",    64'(rd_pc_o),    has ? 64'(mq[0].pc)    : 64'(0));
      chk("rd_instr", 64'(rd_instr_o), has ? 64'(mq[0].instr) : 64'(0));
   endtask

   function automatic void model_update(bit arm, bit stop, bit valid,
                                        logic [DW-1:0] pc, logic [DW-1:0] instr, bit rdy);
      ent_t e;
      if (arm) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_mode = (mode_i == 2'd3) ? 1 : int'(mode_i);
         m_st   = 1;
         m_post = 0;
         return;
      end
      if (m_st == 1 || m_st == 2) begin
         if (valid) begin
            e.pc    = pc;
            e.instr = instr;
            mq.push_back(e);
            if (mq.size() > DEPTH) begin
               void'(mq.pop_front());
               m_ovf = 1'b1;
            end
            if (m_st == 1) begin
               if (m_mode == 1 && mq.size() == DEPTH) m_st = 3;
               else if (m_mode == 2 && pc == trig_pc_i) begin
                  m_post = POST_CNT;
                  m_st   = (POST_CNT == 0) ? 3 : 2;
               end
            end else begin
               m_post--;
               if (m_post == 0) m_st = 3;
            end
         end
         if (stop) m_st = 3;
      end else if (m_st == 3 && rdy && mq.size() > 0) begin
         void'(mq.pop_front());
      end
   endfunction

   // One clock of stimulus: drive, predict any pop for the scoreboard, advance model, check.
   task automatic step(input bit arm, input bit stop, input bit valid,
                       input logic [DW-1:0] pc, input bit rdy);
      logic [DW-1:0] instr;
      instr       = $urandom;
      arm_i       = arm;
      stop_i      = stop;
      cap_valid_i = valid;
      cap_pc_i    = pc;
      cap_instr_i = instr;
      rd_ready_i  = rdy;
      if (!arm && m_st == 3 && mq.size() > 0 && rdy) exp_q.push_back(mq[0]);
      @(posedge clk_i);
      #1;
      model_update(arm, stop, valid, pc, instr, rdy);
      check_outputs();
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      mq.delete();
      exp_q.delete();
      m_st   = 0;
      m_ovf  = 1'b0;
      m_post = 0;
      check_outputs();
      @(posedge clk_i);
      #1;
      check_outputs();
      rst_ni = 1'b1;
   endtask

   // Scoreboard monitor: every accepted read must match the next predicted entry.
   always @(negedge clk_i) begin
      if (rst_ni && !arm_i && rd_valid_o && rd_ready_i) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got pop pc=%0h expected no pop (t=%0t)", rd_pc_o, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (rd_pc_o !== mon_e.pc || rd_instr_o !== mon_e.instr) begin
               n_fail++;
               $display("FAIL pop_data: got %0h/%0h expected %0h/%0h (t=%0t)",
                        rd_pc_o, rd_instr_o, mon_e.pc, mon_e.instr, $time);
            end
         end
      end
   end

   initial begin
      #2;
      do_reset();
      // Idle: captures and stop are ignored.
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, DW'(4 * k), 1'b1);

      // Stop-on-full, with a held read before draining.
      mode_i = 2'b01;
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, DW'(4 * k), 1'b0);
      for (int k = 0; k < 3; k++)  step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 18; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Wrap mode with overwrite, ended by stop.
      mode_i = 2'b00;
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, DW'(4 * k), 1'b0);
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      for (int k = 0; k < 18; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Trigger mode at PC 40.
      mode_i    = 2'b10;
      trig_pc_i = DW'(40);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, DW'(4 * k), 1'b0);
      for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Mode 11 behaves as stop-on-full.
      mode_i = 2'b11;
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 1'b1, DW'(4 * k), 1'b0);
      for (int k = 0; k < 17; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Reset mid-capture, then captures ignored until the next arm.
      mode_i = 2'b00;
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1, DW'(4 * k), 1'b0);
      do_reset();
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, DW'(4 * k), 1'b1);

      // Arm beats coincident stop and capture; alternating valid afterwards.
      step(1'b1, 1'b1, 1'b1, DW'(100), 1'b0);
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, k[0], DW'(4 * k), 1'b0);
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1);

      // Randomised traffic.
      for (int k = 0; k < 600; k++) begin
         mode_i    = 2'($urandom_range(0, 3));
         trig_pc_i = DW'(4 * $urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) do_reset();
         step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
              1'($urandom_range(0, 1)), DW'(4 * $urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
      end

      for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("pending_pops", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
